// File: rtl/serial_frame_receiver_if.sv
// Link bundle between the UART line driver and the frame receiver.
`timescale 1ns/1ps
interface serial_frame_receiver_if;
    logic         rx;
    logic [271:0] sensor_iterations;
    logic         data_valid;
    logic         frame_error;

    modport master (output rx, input sensor_iterations, data_valid, frame_error);
    modport slave  (input rx, output sensor_iterations, data_valid, frame_error);
endinterface

// File: rtl/serial_frame_receiver.sv
// 8N1 deserialiser that locks onto the 51-byte sensor-timing frame
// (three 0x00 sync bytes + sixteen 24-bit words) and republishes the 17-bit payloads.
`timescale 1ns/1ps
module serial_frame_receiver #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int IDLE_GAP_BITS = 20
) (
    input logic               clk_12MHz,
    input logic               rstn,
    serial_frame_receiver_if.slave link
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_MAX  = CLKS_PER_BIT * IDLE_GAP_BITS;
    localparam int GAP_W    = $clog2(GAP_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MAX);

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_START  = 2'd1;
    localparam logic [1:0] R_DATA   = 2'd2;
    localparam logic [1:0] R_STOP   = 2'd3;

    localparam logic [1:0] F_HUNT   = 2'd0;
    localparam logic [1:0] F_SYNC   = 2'd1;
    localparam logic [1:0] F_DATA   = 2'd2;
    localparam logic [1:0] F_COMMIT = 2'd3;

    logic             rx_meta, rx_sync, rx_prev;
    logic             start_edge;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_ok, byte_bad;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap;
    logic [1:0]       f_state;
    logic [5:0]       idx;
    logic [1:0]       word_byte;
    logic [383:0]     staging;
    logic [271:0]     iterations_q;
    logic             data_valid_q, frame_error_q;
    logic             abort;

    always_ff @(posedge clk_12MHz) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= link.rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync & (r_state == R_IDLE);

    // Character receiver: the counter is preloaded with 1 so the start bit is
    // sampled mid-bit despite the synchroniser and edge-detect delay.
    always_ff @(posedge clk_12MHz) begin
        if (!rstn) begin
            r_state  <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;
        end else begin
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (start_edge) begin
                        r_state <= R_START;
                        bit_cnt <= CNT_W'(1);
                    end
                end
                R_START: begin
                    if (bit_cnt == CNT_W'(HALF_BIT)) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        r_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            r_state <= R_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        byte_ok  <= rx_sync;
                        byte_bad <= ~rx_sync;
                        r_state  <= R_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (!rstn)
            gap_cnt <= '0;
        else if (start_edge)
            gap_cnt <= '0;
        else if (r_state == R_IDLE && rx_sync && gap_cnt != GAP_LIMIT)
            gap_cnt <= gap_cnt + GAP_W'(1);
    end

    assign gap = (gap_cnt == GAP_LIMIT);

    // A frame is dropped on a broken character, a nonzero sync byte, a word
    // header carrying more than bit 16, or an idle gap once the frame has begun.
    always_comb begin
        abort = 1'b0;
        case (f_state)
            F_SYNC:  abort = byte_bad || (gap && idx != 6'd0) ||
                             (byte_ok && rx_shift != 8'd0);
            F_DATA:  abort = byte_bad || gap ||
                             (byte_ok && word_byte == 2'd0 && rx_shift[7:1] != 7'd0);
            default: abort = 1'b0;
        endcase
    end

    always_ff @(posedge clk_12MHz) begin
        if (!rstn) begin
            f_state       <= F_HUNT;
            idx           <= '0;
            word_byte     <= '0;
            staging       <= '0;
            iterations_q  <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (abort) begin
                frame_error_q <= 1'b1;
                staging       <= '0;
                idx           <= '0;
                word_byte     <= '0;
                f_state       <= F_HUNT;
            end else begin
                case (f_state)
                    F_HUNT: begin
                        if (gap) begin
                            f_state <= F_SYNC;
                            idx     <= '0;
                        end
                    end
                    F_SYNC: begin
                        if (byte_ok) begin
                            idx <= idx + 6'd1;
                            if (idx == 6'd2) begin
                                f_state   <= F_DATA;
                                word_byte <= '0;
                            end
                        end
                    end
                    F_DATA: begin
                        if (byte_ok) begin
                            staging   <= (staging << 8) | 384'(rx_shift);
                            idx       <= idx + 6'd1;
                            word_byte <= (word_byte == 2'd2) ? 2'd0 : word_byte + 2'd1;
                            if (idx == 6'd50)
                                f_state <= F_COMMIT;
                        end
                    end
                    default: begin
                        for (int k = 0; k < 16; k++)
                            iterations_q[271-17*k -: 17] <= staging[376-24*k -: 17];
                        data_valid_q <= 1'b1;
                        staging      <= '0;
                        idx          <= '0;
                        f_state      <= F_HUNT;
                    end
                endcase
            end
        end
    end

    assign link.sensor_iterations = iterations_q;
    assign link.data_valid        = data_valid_q;
    assign link.frame_error       = frame_error_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: drives 8N1 frames at a shortened bit
// period and compares the published vector and status pulses with hand-built frames.
`timescale 1ns/1ps
module tb_serial_frame_receiver;
    localparam int CLKS     = 8;
    localparam int GAP_BITS = 20;

    logic clk_12MHz = 1'b0;
    logic rstn      = 1'b0;

    always #5 clk_12MHz = ~clk_12MHz;

    serial_frame_receiver_if link();

    serial_frame_receiver #(
        .CLKS_PER_BIT (CLKS),
        .IDLE_GAP_BITS(GAP_BITS)
    ) dut (
        .clk_12MHz(clk_12MHz),
        .rstn     (rstn),
        .link     (link.slave)
    );

    int checks   = 0;
    int failures = 0;
    int dv_count = 0, fe_count = 0, overlap_count = 0, long_pulse_count = 0;
    int dv0, fe0;
    logic dv_prev = 1'b0, fe_prev = 1'b0;

    logic [16:0]  vals [16];
    logic [7:0]   frame_bytes [51];
    logic [271:0] frame_exp, held_exp;

    // Pulse monitor, sampled shortly after each rising edge.
    always @(posedge clk_12MHz) begin
        #2;
        if (link.data_valid) dv_count <= dv_count + 1;
        if (link.frame_error) fe_count <= fe_count + 1;
        if (link.data_valid && link.frame_error) overlap_count <= overlap_count + 1;
        if ((link.data_valid && dv_prev) || (link.frame_error && fe_prev))
            long_pulse_count <= long_pulse_count + 1;
        dv_prev <= link.data_valid;
        fe_prev <= link.frame_error;
    end

    task automatic checkOutput(input string tag, input logic [271:0] actual,
                               input logic [271:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic setVals(input int kind);
        for (int k = 0; k < 16; k++) begin
            case (kind)
                0:       vals[k] = 17'h0;
                1:       vals[k] = (k == 0) ? 17'h1ABCD : 17'h00005;
                2:       vals[k] = 17'(k * 17'h1111 + 17'h0F0F);
                3:       vals[k] = 17'(17'h1FFFF - k);
                4:       vals[k] = 17'(k * 3 + 17'h00100);
                default: vals[k] = 17'((k << 13) | 17'h000A5);
            endcase
        end
    endtask

    task automatic buildFrame();
        for (int i = 0; i < 3; i++) frame_bytes[i] = 8'h00;
        for (int k = 0; k < 16; k++) begin
            frame_bytes[3+3*k] = {7'd0, vals[k][16]};
            frame_bytes[4+3*k] = vals[k][15:8];
            frame_bytes[5+3*k] = vals[k][7:0];
            frame_exp[271-17*k -: 17] = vals[k];
        end
    endtask

    task automatic idleBits(input int n);
        link.rx = 1'b1;
        repeat (n * CLKS) @(negedge clk_12MHz);
    endtask

    // rst_cycle >= 0 pulls rstn low for that one cycle of the character.
    task automatic sendByte(input logic [7:0] b, input bit stop_ok, input int rst_cycle);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            link.rx = bits[i];
            for (int c = 0; c < CLKS; c++) begin
                if (rst_cycle >= 0) rstn = ((i * CLKS + c) != rst_cycle);
                @(negedge clk_12MHz);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic applyStimulus(input int first, input int last);
        for (int i = first; i <= last; i++) sendByte(frame_bytes[i], 1'b1, -1);
    endtask

    task automatic snap();
        dv0 = dv_count;
        fe0 = fe_count;
    endtask

    task automatic settle();
        link.rx = 1'b1;
        repeat (2) @(negedge clk_12MHz);
    endtask

    initial begin
        link.rx = 1'b1;
        rstn    = 1'b0;
        repeat (4) @(negedge clk_12MHz);
        checkOutput("reset_vector", link.sensor_iterations, 272'(0));
        checkOutput("reset_valid", 272'(link.data_valid), 272'(0));
        checkOutput("reset_error", 272'(link.frame_error), 272'(0));
        rstn = 1'b1;

        // Short low glitch on an idle line.
        idleBits(GAP_BITS + 5);
        snap();
        link.rx = 1'b0;
        repeat (3) @(negedge clk_12MHz);
        idleBits(5);
        checkOutput("glitch_valid", 272'(dv_count - dv0), 272'(0));
        checkOutput("glitch_error", 272'(fe_count - fe0), 272'(0));

        // All-zero frame: one lock only.
        setVals(0); buildFrame();
        idleBits(GAP_BITS + 5); snap();
        applyStimulus(0, 50); idleBits(GAP_BITS + 5);
        checkOutput("zero_valid", 272'(dv_count - dv0), 272'(1));
        checkOutput("zero_error", 272'(fe_count - fe0), 272'(0));
        checkOutput("zero_vector", link.sensor_iterations, 272'(0));

        // Nominal frame.
        setVals(1); buildFrame(); snap();
        applyStimulus(0, 50); settle();
        checkOutput("nom_valid", 272'(dv_count - dv0), 272'(1));
        checkOutput("nom_error", 272'(fe_count - fe0), 272'(0));
        checkOutput("nom_word0", 272'(link.sensor_iterations[271:255]), 272'(17'h1ABCD));
        checkOutput("nom_word15", 272'(link.sensor_iterations[16:0]), 272'(17'h00005));
        checkOutput("nom_vector", link.sensor_iterations, frame_exp);
        held_exp = frame_exp;

        // Bad word header on byte 6.
        setVals(2); buildFrame(); frame_bytes[6] = 8'h02;
        idleBits(GAP_BITS + 5); snap();
        applyStimulus(0, 5);
        checkOutput("hdr_early", 272'(fe_count - fe0), 272'(0));
        sendByte(frame_bytes[6], 1'b1, -1); settle();
        checkOutput("hdr_error", 272'(fe_count - fe0), 272'(1));
        applyStimulus(7, 50); settle();
        checkOutput("hdr_single", 272'(fe_count - fe0), 272'(1));
        checkOutput("hdr_valid", 272'(dv_count - dv0), 272'(0));
        checkOutput("hdr_hold", link.sensor_iterations, held_exp);
        buildFrame();
        idleBits(GAP_BITS + 5); snap();
        applyStimulus(0, 50); settle();
        checkOutput("hdr_recover_valid", 272'(dv_count - dv0), 272'(1));
        checkOutput("hdr_recover_vector", link.sensor_iterations, frame_exp);
        held_exp = frame_exp;

        // Truncated frame after byte 20.
        setVals(3); buildFrame();
        idleBits(GAP_BITS + 5); snap();
        applyStimulus(0, 20); idleBits(GAP_BITS - 2);
        checkOutput("trunc_early", 272'(fe_count - fe0), 272'(0));
        idleBits(7);
        checkOutput("trunc_error", 272'(fe_count - fe0), 272'(1));
        checkOutput("trunc_valid", 272'(dv_count - dv0), 272'(0));
        checkOutput("trunc_hold", link.sensor_iterations, held_exp);
        snap();
        applyStimulus(0, 50); settle();
        checkOutput("trunc_recover_valid", 272'(dv_count - dv0), 272'(1));
        checkOutput("trunc_recover_vector", link.sensor_iterations, frame_exp);
        held_exp = frame_exp;

        // Stop bit low on byte 10.
        setVals(4); buildFrame();
        idleBits(GAP_BITS + 5); snap();
        applyStimulus(0, 9);
        checkOutput("stop_early", 272'(fe_count - fe0), 272'(0));
        sendByte(frame_bytes[10], 1'b0, -1); settle();
        checkOutput("stop_error", 272'(fe_count - fe0), 272'(1));
        idleBits(GAP_BITS + 5);
        checkOutput("stop_valid", 272'(dv_count - dv0), 272'(0));
        checkOutput("stop_hold", link.sensor_iterations, held_exp);

        // Reset pulse during byte 30.
        setVals(5); buildFrame(); snap();
        applyStimulus(0, 29);
        sendByte(frame_bytes[30], 1'b1, 20);
        checkOutput("rst_vector", link.sensor_iterations, 272'(0));
        checkOutput("rst_valid", 272'(link.data_valid), 272'(0));
        checkOutput("rst_error", 272'(link.frame_error), 272'(0));
        applyStimulus(31, 50); idleBits(GAP_BITS + 5);
        checkOutput("rst_ignored_valid", 272'(dv_count - dv0), 272'(0));
        checkOutput("rst_ignored_error", 272'(fe_count - fe0), 272'(0));
        checkOutput("rst_ignored_vector", link.sensor_iterations, 272'(0));
        snap();
        applyStimulus(0, 50); settle();
        checkOutput("rst_recover_valid", 272'(dv_count - dv0), 272'(1));
        checkOutput("rst_recover_vector", link.sensor_iterations, frame_exp);

        checkOutput("pulse_overlap", 272'(overlap_count), 272'(0));
        checkOutput("pulse_width", 272'(long_pulse_count), 272'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receive side of the sensor-timing UART link. It deserialises 8N1 characters from `rx` and locks onto the 51-byte frame. The frame is three 0x00 sync bytes followed by sixteen 24-bit big-endian words, each carrying a 17-bit sensor iteration value in bits [16:0]. The block rebuilds the 272-bit `sensor_iterations` vector and flags each complete, well-formed frame. It sits on the host-side FPGA or in loopback benches, mirroring the transmitter's packing exactly.

## Interface
- `CLKS_PER_BIT`, 104, clk_12MHz cycles per UART bit (115200 baud).
- `IDLE_GAP_BITS`, 20, bit periods of continuous idle-high line that mark a frame boundary.
- `clk_12MHz`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low; clock clk_12MHz.
- `rx`  in  1  asynchronous UART line; idle high.
- `sensor_iterations`  out  272  last valid frame; word k (k=0..15) in bits [271-17k : 255-17k]; word order is iter0_s0, iter1_s0, iter0_s1, …, iter1_s7.
- `data_valid`  out  1  one-cycle pulse: `sensor_iterations` was just updated.
- `frame_error`  out  1  one-cycle pulse: the current frame was aborted.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised signal.
- **Character RX FSM** (R_IDLE, R_START, R_DATA, R_STOP):
  - R_IDLE: a falling edge goes to R_START.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. Low goes to R_DATA; high is a glitch and returns to R_IDLE with no error.
  - R_DATA: sample 8 bits LSB first, CLKS_PER_BIT apart.
  - R_STOP: sample after CLKS_PER_BIT. High gives `byte_ok` for one cycle. Low gives `byte_bad`. Both return to R_IDLE.
- **Idle-gap counter:**
  - Counts cycles while the line is high and the char FSM is in R_IDLE.
  - Clears on any start-bit edge.
  - Saturates at CLKS_PER_BIT*IDLE_GAP_BITS; reaching that value raises `gap`.
- **Frame FSM** (F_HUNT, F_SYNC, F_DATA, F_COMMIT), with a 6-bit byte counter `idx`:
  - F_HUNT: wait for `gap`, then go to F_SYNC with idx=0. Bytes received in F_HUNT are discarded silently.
  - F_SYNC: each `byte_ok` must equal 0x00; idx increments. After idx reaches 3, go to F_DATA. A nonzero byte aborts.
  - F_DATA: bytes are shifted into a 384-bit staging register, MSB byte first. For each word's first byte (idx = 3,6,…,48), bits [7:1] must be 0; otherwise abort. After byte idx=50, go to F_COMMIT.
  - F_COMMIT: for each of the 16 words, copy the low 17 bits into `sensor_iterations`. Pulse `data_valid`, then go to F_HUNT.
- **Abort conditions** (each pulses `frame_error` for one cycle, clears the staging register and idx, and returns to F_HUNT):
  - `byte_bad` in F_SYNC or F_DATA.
  - Bad sync byte.
  - Bad word header.
  - `gap` asserted while in F_SYNC with idx>0, or in F_DATA (truncated frame).
- **Output hold:** `sensor_iterations` changes only in F_COMMIT. Aborted frames never alter it.
- **Resync:** F_HUNT always demands a fresh idle gap. Back-to-back frames without a gap of at least IDLE_GAP_BITS are dropped.

## Timing
- **Reset values:** `sensor_iterations`=0, `data_valid`=0, `frame_error`=0, char FSM R_IDLE, frame FSM F_HUNT, gap counter 0.
- **Reset mid-frame:** the partial frame is discarded; the outputs take their reset values on the next edge.
- **Sampling point:** the start bit is sampled 2 + CLKS_PER_BIT/2 cycles after the line falls (synchroniser delay included).
- **Valid latency:** `data_valid` rises 2 cycles after the stop-bit sample of byte 50 (`byte_ok`, then F_COMMIT). `sensor_iterations` takes its new value on the same edge.
- **Error latency:** `frame_error` rises 1 cycle after the offending `byte_ok`, `byte_bad` or `gap`.
- **Mutual exclusion:** `data_valid` and `frame_error` are never high together.
- **Counter widths:** the bit counter is ceil(log2(CLKS_PER_BIT)) bits. The gap counter is wide enough for CLKS_PER_BIT*IDLE_GAP_BITS (12 bits at the defaults).

## Test plan
- **Nominal frame:** idle ≥20 bits, then frame 00 00 00, 01 AB CD, then 15 words 00 00 05.
  - `data_valid` pulses once.
  - `sensor_iterations[271:255]`=17'h1ABCD and `[16:0]`=17'h00005.
  - `frame_error` stays 0.
- **Zero payload ambiguity:** all words = 0 (51 × 0x00) after a gap.
  - Exactly one `data_valid`; vector all zero.
  - No second lock on the embedded zeros.
- **Bad header:** byte 6 = 0x02.
  - `frame_error` pulses one cycle after it.
  - `sensor_iterations` keeps the previous frame.
  - The next gapped, valid frame is accepted.
- **Truncation:** stop after byte 20, idle 25 bits.
  - `frame_error` pulses when `gap` is reached.
  - Then a full frame gives `data_valid`.
- **Framing error:** stop bit forced low on byte 10 → `frame_error`, no `data_valid`.
  - Glitch test: a 20-cycle low pulse on idle gives no byte and no error.
- **Reset:** `rstn`=0 for 1 cycle during byte 30.
  - Outputs read 0 after reset.
  - The remaining bytes are ignored.
  - The following gapped frame is accepted.
